// File: rtl/sync_fifo_prog_if.sv
// Handshake and status bundle between a same-clock producer/consumer and sync_fifo_prog.
// master drives write/read requests; slave is the FIFO.
interface sync_fifo_prog_if #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost flags, overflow/underflow
// pulses and a selectable standard or first-word-fall-through read port.
module sync_fifo_prog #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_prog_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "sync_fifo_prog: DEPTH must be a power of two and >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $fatal(1, "sync_fifo_prog: AF_THRESH must be in 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
        $fatal(1, "sync_fifo_prog: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  full, empty, wr_acc, rd_acc;

    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    assign wr_acc = bus.wr_en && !full;
    assign rd_acc = bus.rd_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = bus.wr_en && full;
        underflow_d = bus.rd_en && empty;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage carries no reset so it can map onto plain register-file/RAM cells.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    if (FWFT != 0) begin : g_fwft
        // Forced to zero while empty so the port is quiet at reset and after a drain.
        assign bus.rd_data = empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)        rd_data_q <= '0;
            else if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
        end
        assign bus.rd_data = rd_data_q;
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
- Single-clock, parametrised FIFO for same-domain buffering.
- Successor to the dual-clock FIFO, but with no pointer synchronisers.
- Adds an occupancy count, programmable almost_full/almost_empty thresholds, sticky-free overflow/underflow pulses, and a selectable first-word-fall-through (FWFT) read mode.
- Used wherever producer and consumer share clk.

Parameters:
DEPTH, 16, number of entries; power of two, >= 2
DATA_WIDTH, 8, width of each entry in bits
AF_THRESH, DEPTH-4, almost_full asserts when count >= AF_THRESH; legal 1..DEPTH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal 0..DEPTH-1
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  single clock, rising-edge
rst  input  1  asynchronous, active-low reset; rst=0 resets all state immediately; release is synchronous to clk at the source
wr_en  input  1  write request
wr_data  input  DATA_WIDTH  write data, sampled on accepted write
rd_en  input  1  read request (FWFT=1: acknowledge/pop of head word)
rd_data  output  DATA_WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write attempted while full
underflow  output  1  one-cycle pulse: read attempted while empty

Behaviour:

Storage and pointers:
- Memory holds DEPTH x DATA_WIDTH entries and is not reset.
- wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- count is a separate register of width $clog2(DEPTH)+1.

Reset (rst=0):
- wr_ptr=0, rd_ptr=0, count=0, rd_data=0, overflow=0, underflow=0.
- Hence empty=1, full=0, almost_empty=1, almost_full=0.
- Reset mid-operation discards all contents. The first accepted write after release behaves as a write to an empty FIFO.

Transfer acceptance:
- Write accepted: wr_en && !full. Memory is written at wr_ptr, wr_ptr increments.
- Read accepted: rd_en && !empty. rd_ptr increments.
- Full with wr_en and rd_en together: only the read is accepted. The write is rejected and overflow pulses.
- Empty with both asserted: only the write is accepted. The read is rejected and underflow pulses. No write-through bypass.

count update:
- Write only: +1.
- Read only: -1.
- Both accepted, or neither: unchanged.

Flags:
- full, empty, almost_full and almost_empty are pure decodes of the registered count. They change in the cycle after the edge that changed count.

overflow / underflow:
- overflow is registered and equals 1 for exactly the cycle after an edge where wr_en && full. underflow is the same for rd_en && empty.
- Pointers, count and memory are unchanged by a rejected request.
- Not sticky.

FWFT=0 (standard read):
- On an accepted read, rd_data <= mem[rd_ptr] at that edge, so data is valid the cycle after rd_en.
- rd_data holds its value otherwise, including on underflow.

FWFT=1 (first-word-fall-through):
- rd_data = mem[rd_ptr] whenever empty=0.
- The first word written into an empty FIFO appears on rd_data, with empty=0, in the cycle after the write edge.
- An accepted rd_en pops the head word; the next word, if any, is on rd_data the following cycle.
- rd_data is don't-care while empty=1.

Elaboration checks:
- Fatal if DEPTH is not a power of two or is < 2.
- Fatal if AF_THRESH is outside 1..DEPTH.
- Fatal if AE_THRESH is outside 0..DEPTH-1.

Test Plan:
All scenarios use DEPTH=16, DATA_WIDTH=8, AF_THRESH=12, AE_THRESH=2.
1. Reset, then 16 writes 0x00..0x0F, no reads -> count steps 1..16; almost_empty drops after the 3rd write (count=3); almost_full rises at count=12; full=1 after the 16th write; a 17th wr_en gives one overflow pulse, count stays 16.
2. FWFT=0: from test 1's full FIFO, 16 back-to-back reads -> rd_data 0x00..0x0F, each one cycle after its rd_en; empty=1 after the last; an extra rd_en gives one underflow pulse and rd_data holds 0x0F.
3. Wrap-around: 10 writes, 10 reads, repeated 3 times with incrementing data -> output order preserved across pointer wrap; count returns to 0 each round.
4. Simultaneous: at count=5, wr_en=rd_en=1 for 8 cycles -> count stays 5 and no pulses. At full, both asserted -> read accepted, write rejected, overflow=1, count=15. At empty, both asserted -> write accepted, underflow=1, count=1.
5. FWFT=1: write 0xA5 into empty FIFO -> next cycle empty=0 and rd_data=0xA5 with no rd_en; write 0x5A, then rd_en -> rd_data=0x5A the following cycle.
6. Assert rst=0 mid-burst at count=7, asynchronous to clk -> outputs reach reset values immediately without a clock edge; after release, write 0x33 then read -> rd_data=0x33.
